// File: rtl/heap_pkg.sv
// Shared types for the heap array unit: request action codes and the request FSM states.
package heap_pkg;

  typedef enum logic [7:0] {
    NOP   = 8'd0,
    CLEAR = 8'd1,
    ALLOC = 8'd2,
    FREE  = 8'd3,
    WRITE = 8'd4,
    READ  = 8'd5,
    SIZE  = 8'd6,
    PUSH  = 8'd7,
    POP   = 8'd8
  } action_t;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  // Actions that target an existing array id and so depend on its allocation state.
  function automatic logic is_array_access(input logic [7:0] act);
    return (act >= 8'(FREE)) && (act <= 8'(POP));
  endfunction

endpackage

// File: rtl/heap_free_list.sv
// LIFO of free array ids; reset/clear refills it so id 0 is popped first.
module heap_free_list #(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_srst,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  logic [$clog2(DEPTH)-1:0] i_push_id,
  input  logic                     i_pop,
  output logic [$clog2(DEPTH)-1:0] o_top,
  output logic                     o_empty,
  output logic                     o_full
);
  localparam int IDW = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);

  logic [IDW-1:0] r_stack [DEPTH];
  logic [CW-1:0]  r_count;

  always_ff @(posedge i_clk) begin
    if (i_srst || i_clear) begin
      r_count <= CW'(DEPTH);
      for (int k = 0; k < DEPTH; k++) r_stack[k] <= IDW'(DEPTH - 1 - k);
    end else if (i_push && !o_full) begin
      r_stack[IDW'(r_count)] <= i_push_id;
      r_count <= r_count + CW'(1);
    end else if (i_pop && !o_empty) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign o_top   = r_stack[IDW'(r_count - CW'(1))];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));

endmodule

// File: rtl/heap_array_unit.sv
// Heap array store: alloc/free/read/write/push/pop on fixed-size word arrays, one request per 3 cycles.
// Define HEAP_BOUNDS_CHECK_EN to flag and suppress accesses to unallocated ids and out-of-range elements.
module heap_array_unit
  import heap_pkg::*;
#(
  parameter int WIDTH      = 12,
  parameter int ARRAYS     = 4,
  parameter int ARRAY_SIZE = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [7:0]                    req_action,
  input  logic [$clog2(ARRAYS)-1:0]     req_array,
  input  logic [$clog2(ARRAY_SIZE)-1:0] req_index,
  input  logic [WIDTH-1:0]              req_data,
  output logic                          resp_valid,
  output logic [WIDTH-1:0]              resp_data,
  output logic                          resp_err,
  output logic [$clog2(ARRAYS+1)-1:0]   allocated
);
  localparam int AW    = $clog2(ARRAYS);
  localparam int IW    = $clog2(ARRAY_SIZE);
  localparam int SW    = $clog2(ARRAY_SIZE + 1);
  localparam int CW    = $clog2(ARRAYS + 1);
  localparam int DEPTH = ARRAYS * ARRAY_SIZE;
  localparam int MW    = $clog2(DEPTH);
`ifdef HEAP_BOUNDS_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  state_t          r_state;
  logic [7:0]      r_action;
  logic [AW-1:0]   r_array;
  logic [IW-1:0]   r_index;
  logic [WIDTH-1:0] r_data, r_res_data, r_resp_data;
  logic            r_res_err, r_resp_err, r_resp_valid;
  logic [CW-1:0]   r_allocated;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [SW-1:0]   w_size [ARRAYS];
  logic [ARRAYS-1:0] w_bitmap, w_size_we, w_bm_set, w_bm_clr;
  logic [SW-1:0]   w_sz, w_size_wd, w_idx_p1;
  logic            w_owned, w_guard, w_clear, w_fl_push, w_fl_pop, w_fl_empty, w_fl_full;
  logic            w_alloc_inc, w_alloc_dec, w_mem_we, w_res_err;
  logic [AW-1:0]   w_fl_top;
  logic [MW-1:0]   w_base, w_rd_addr, w_wr_addr;
  logic [WIDTH-1:0] w_rd_word, w_res_data;

  assign w_sz      = w_size[r_array];
  assign w_owned   = w_bitmap[r_array];
  assign w_idx_p1  = SW'(r_index) + SW'(1);
  assign w_guard   = CHECK && is_array_access(r_action) && !w_owned;
  assign w_base    = MW'(int'(r_array) * ARRAY_SIZE);
  // POP reads the slot below the current size; PUSH writes the slot at the current size.
  assign w_rd_addr = w_base + MW'((r_action == 8'(POP)) ? IW'(w_sz - SW'(1)) : r_index);
  assign w_wr_addr = w_base + MW'((r_action == 8'(PUSH)) ? IW'(w_sz) : r_index);
  assign w_rd_word = r_mem[w_rd_addr];

  always_comb begin
    w_res_data = '0; w_res_err = 1'b0; w_clear = 1'b0;
    w_fl_push = 1'b0; w_fl_pop = 1'b0; w_alloc_inc = 1'b0; w_alloc_dec = 1'b0;
    w_size_we = '0; w_size_wd = '0; w_bm_set = '0; w_bm_clr = '0; w_mem_we = 1'b0;
    if (r_state == EXEC) begin
      if (w_guard) begin
        w_res_err = 1'b1;
      end else begin
        case (r_action)
          8'(NOP):   ;
          8'(CLEAR): w_clear = 1'b1;
          8'(ALLOC): begin
            if (w_fl_empty) w_res_err = 1'b1;
            else begin
              w_fl_pop = 1'b1; w_alloc_inc = 1'b1; w_res_data = WIDTH'(w_fl_top);
              w_size_we[w_fl_top] = 1'b1; w_bm_set[w_fl_top] = 1'b1;
            end
          end
          8'(FREE): begin
            if (w_owned && !w_fl_full) begin
              w_fl_push = 1'b1; w_alloc_dec = 1'b1; w_bm_clr[r_array] = 1'b1;
            end
          end
          8'(WRITE): begin
            w_mem_we = 1'b1;
            if (w_idx_p1 > w_sz) begin
              w_size_we[r_array] = 1'b1; w_size_wd = w_idx_p1;
            end
          end
          8'(READ): begin
            if (CHECK && (w_idx_p1 > w_sz)) w_res_err = 1'b1;
            else w_res_data = w_rd_word;
          end
          8'(SIZE): w_res_data = WIDTH'(w_sz);
          8'(PUSH): begin
            if (w_sz == SW'(ARRAY_SIZE)) w_res_err = CHECK;
            else begin
              w_mem_we = 1'b1; w_size_we[r_array] = 1'b1; w_size_wd = w_sz + SW'(1);
            end
          end
          8'(POP): begin
            if (w_sz == '0) w_res_err = CHECK;
            else begin
              w_res_data = w_rd_word; w_size_we[r_array] = 1'b1; w_size_wd = w_sz - SW'(1);
            end
          end
          default: w_res_err = 1'b1;
        endcase
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ARRAYS; gi++) begin : g_array
      logic [SW-1:0] r_size;
      logic          r_owned;
      always_ff @(posedge clock) begin
        if (reset || w_clear) begin
          r_size  <= '0;
          r_owned <= 1'b0;
        end else begin
          if (w_size_we[gi]) r_size <= w_size_wd;
          if (w_bm_set[gi]) r_owned <= 1'b1;
          else if (w_bm_clr[gi]) r_owned <= 1'b0;
        end
      end
      assign w_size[gi]   = r_size;
      assign w_bitmap[gi] = r_owned;
    end
  endgenerate

  // Element storage survives reset; a reset landing in EXEC must still suppress the write.
  always_ff @(posedge clock) begin
    if (!reset && w_mem_we) r_mem[w_wr_addr] <= r_data;
  end

  heap_free_list #(.DEPTH(ARRAYS)) u_free_list (
    .i_clk    (clock),
    .i_srst   (reset),
    .i_clear  (w_clear),
    .i_push   (w_fl_push),
    .i_push_id(r_array),
    .i_pop    (w_fl_pop),
    .o_top    (w_fl_top),
    .o_empty  (w_fl_empty),
    .o_full   (w_fl_full)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE; r_action <= '0; r_array <= '0; r_index <= '0; r_data <= '0;
      r_res_data <= '0; r_res_err <= 1'b0; r_resp_valid <= 1'b0;
      r_resp_data <= '0; r_resp_err <= 1'b0; r_allocated <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        IDLE: if (req_valid) begin
          r_action <= req_action; r_array <= req_array;
          r_index <= req_index; r_data <= req_data;
          r_state <= EXEC;
        end
        EXEC: begin
          r_res_data <= w_res_data;
          r_res_err  <= w_res_err;
          if (w_clear) r_allocated <= '0;
          else if (w_alloc_inc) r_allocated <= r_allocated + CW'(1);
          else if (w_alloc_dec) r_allocated <= r_allocated - CW'(1);
          r_state <= RESP;
        end
        RESP: begin
          r_resp_valid <= 1'b1;
          r_resp_data  <= r_res_data;
          r_resp_err   <= r_res_err;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_err   = r_resp_err;
  assign allocated  = r_allocated;

endmodule

// File: tb/tb_heap_array_unit.sv
// Directed self-checking bench for heap_array_unit with hand-computed expectations.
`timescale 1ns/1ps
module tb_heap_array_unit;
  import heap_pkg::*;

`ifdef HEAP_BOUNDS_CHECK_EN
  localparam bit EXP_CHECK = 1'b1;
`else
  localparam bit EXP_CHECK = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_action;
  logic [1:0]  req_array;
  logic [2:0]  req_index;
  logic [11:0] req_data;
  logic        resp_valid;
  logic [11:0] resp_data;
  logic        resp_err;
  logic [2:0]  allocated;

  int checks = 0;
  int errors = 0;

  heap_array_unit dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_action(req_action),
    .req_array (req_array),
    .req_index (req_index),
    .req_data  (req_data),
    .resp_valid(resp_valid),
    .resp_data (resp_data),
    .resp_err  (resp_err),
    .allocated (allocated)
  );

  always #5 clock = ~clock;

  // Issue one request, return the response and the number of edges from accept to resp_valid.
  task automatic do_req(input logic [7:0] act, input logic [1:0] arr, input logic [2:0] idx,
                        input logic [11:0] d, output logic [11:0] rd, output logic re, output int lat);
    int n;
    @(negedge clock);
    req_valid = 1'b1; req_action = act; req_array = arr; req_index = idx; req_data = d;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clock); n++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL req_ready_timeout got %0d want 1", req_ready);
    end
    @(posedge clock);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin @(posedge clock); #1; lat++; end while (!resp_valid && lat < 10);
    if (!resp_valid) begin
      checks++; errors++;
      $display("FAIL resp_timeout got %0d want 1", resp_valid);
    end
    rd = resp_data; re = resp_err;
    $display("req act=%0d arr=%0d idx=%0d data=%0d -> resp data=%0d err=%0d lat=%0d alloc=%0d",
             act, arr, idx, d, rd, re, lat, allocated);
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_action = '0; req_array = '0; req_index = '0; req_data = '0;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0d want 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %0d want 0", resp_valid); end
    checks++; if (resp_data !== 12'd0) begin errors++; $display("FAIL reset_resp_data got %0d want 0", resp_data); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got %0d want 0", resp_err); end
    checks++; if (allocated !== 3'd0) begin errors++; $display("FAIL reset_allocated got %0d want 0", allocated); end
    @(negedge clock) reset = 1'b0;
  endtask

  task automatic test_alloc();
    logic [11:0] d; logic e; int lat;
    for (int k = 0; k < 4; k++) begin
      do_req(ALLOC, 2'd0, 3'd0, 12'd0, d, e, lat);
      checks++;
      if (d !== 12'(k) || e !== 1'b0) begin
        errors++; $display("FAIL alloc_id got %0d/%0d want %0d/0", d, e, k);
      end
    end
    checks++; if (allocated !== 3'd4) begin errors++; $display("FAIL alloc_count got %0d want 4", allocated); end
    do_req(ALLOC, 2'd0, 3'd0, 12'd0, d, e, lat);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL alloc_empty_err got %0d want 1", e); end
    checks++; if (d !== 12'd0) begin errors++; $display("FAIL alloc_empty_data got %0d want 0", d); end
    checks++; if (allocated !== 3'd4) begin errors++; $display("FAIL alloc_empty_count got %0d want 4", allocated); end
  endtask

  task automatic test_write_read();
    logic [11:0] d; logic e; int lat;
    do_req(CLEAR, 2'd0, 3'd0, 12'd0, d, e, lat);
    checks++; if (allocated !== 3'd0 || e !== 1'b0) begin errors++; $display("FAIL clear_state got %0d/%0d want 0/0", allocated, e); end
    do_req(ALLOC, 2'd0, 3'd0, 12'd0, d, e, lat);
    checks++; if (d !== 12'd0) begin errors++; $display("FAIL wr_alloc_id got %0d want 0", d); end
    do_req(WRITE, 2'd0, 3'd3, 12'd5, d, e, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL resp_latency got %0d want 2", lat); end
    @(posedge clock); #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL resp_one_cycle got %0d want 0", resp_valid); end
    do_req(SIZE, 2'd0, 3'd0, 12'd0, d, e, lat);
    checks++; if (d !== 12'd4) begin errors++; $display("FAIL size_after_write got %0d want 4", d); end
    do_req(READ, 2'd0, 3'd3, 12'd0, d, e, lat);
    checks++; if (d !== 12'd5 || e !== 1'b0) begin errors++; $display("FAIL read_back got %0d/%0d want 5/0", d, e); end
  endtask

  task automatic test_push_pop();
    logic [11:0] d; logic e; int lat;
    do_req(ALLOC, 2'd0, 3'd0, 12'd0, d, e, lat);
    checks++; if (d !== 12'd1) begin errors++; $display("FAIL pp_alloc_id got %0d want 1", d); end
    do_req(PUSH, 2'd1, 3'd0, 12'd7, d, e, lat);
    do_req(PUSH, 2'd1, 3'd0, 12'd9, d, e, lat);
    do_req(SIZE, 2'd1, 3'd0, 12'd0, d, e, lat);
    checks++; if (d !== 12'd2) begin errors++; $display("FAIL push_size got %0d want 2", d); end
    do_req(POP, 2'd1, 3'd0, 12'd0, d, e, lat);
    checks++; if (d !== 12'd9) begin errors++; $display("FAIL pop_first got %0d want 9", d); end
    do_req(POP, 2'd1, 3'd0, 12'd0, d, e, lat);
    checks++; if (d !== 12'd7) begin errors++; $display("FAIL pop_second got %0d want 7", d); end
    do_req(POP, 2'd1, 3'd0, 12'd0, d, e, lat);
    checks++; if (d !== 12'd0 || e !== EXP_CHECK) begin errors++; $display("FAIL pop_empty got %0d/%0d want 0/%0d", d, e, EXP_CHECK); end
  endtask

  task automatic test_free();
    logic [11:0] d; logic e; int lat;
    do_req(FREE, 2'd1, 3'd0, 12'd0, d, e, lat);
    checks++; if (allocated !== 3'd1) begin errors++; $display("FAIL free_count got %0d want 1", allocated); end
    do_req(ALLOC, 2'd0, 3'd0, 12'd0, d, e, lat);
    checks++; if (d !== 12'd1) begin errors++; $display("FAIL realloc_id got %0d want 1", d); end
    do_req(FREE, 2'd1, 3'd0, 12'd0, d, e, lat);
    do_req(FREE, 2'd1, 3'd0, 12'd0, d, e, lat);
    checks++; if (allocated !== 3'd1) begin errors++; $display("FAIL double_free_count got %0d want 1", allocated); end
    checks++; if (e !== EXP_CHECK) begin errors++; $display("FAIL double_free_err got %0d want %0d", e, EXP_CHECK); end
    do_req(ALLOC, 2'd0, 3'd0, 12'd0, d, e, lat);
    checks++; if (d !== 12'd1 || allocated !== 3'd2) begin errors++; $display("FAIL alloc_after_free got %0d/%0d want 1/2", d, allocated); end
  endtask

  task automatic test_reset_mid();
    logic [11:0] d; logic e; int lat; logic seen;
    seen = 1'b0;
    @(negedge clock);
    req_valid = 1'b1; req_action = WRITE; req_array = 2'd0; req_index = 3'd2; req_data = 12'd77;
    @(posedge clock);
    #1 req_valid = 1'b0; reset = 1'b1;
    repeat (3) begin @(posedge clock); #1; if (resp_valid) seen = 1'b1; end
    checks++; if (resp_data !== 12'd0) begin errors++; $display("FAIL midreset_resp_data got %0d want 0", resp_data); end
    @(negedge clock) reset = 1'b0;
    repeat (5) begin @(posedge clock); #1; if (resp_valid) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midreset_no_resp got %0d want 0", seen); end
    checks++; if (allocated !== 3'd0) begin errors++; $display("FAIL midreset_allocated got %0d want 0", allocated); end
    do_req(SIZE, 2'd0, 3'd0, 12'd0, d, e, lat);
    checks++; if (d !== 12'd0 || e !== EXP_CHECK) begin errors++; $display("FAIL midreset_size got %0d/%0d want 0/%0d", d, e, EXP_CHECK); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] d; logic e; int lat;
    do_req(8'd200, 2'd0, 3'd0, 12'd0, d, e, lat);
    checks++; if (e !== 1'b1 || d !== 12'd0) begin errors++; $display("FAIL bad_action got %0d/%0d want 0/1", d, e); end
    @(negedge clock);
    req_valid = 1'b1; req_action = NOP; req_array = '0; req_index = '0; req_data = '0;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) @(negedge clock);
      checks++;
      if (req_ready !== ((k % 3) == 0)) begin
        errors++; $display("FAIL b2b_ready_cycle%0d got %0d want %0d", k, req_ready, (k % 3) == 0);
      end
    end
    req_valid = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL b2b_nop_err got %0d want 0", resp_err); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alloc();
    test_write_read();
    test_push_pop();
    test_free();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
